// File: rtl/lcd_bus_responder.sv
// HD44780-compatible panel-side responder. Decodes LCD bus writes into a 2x16 DDRAM mirror and answers busy/data reads.
// Optional macro LCD_BUSY_CHECK_EN: writes arriving while busy are discarded and flagged on viol.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 76500,
    parameter int SYNC_STAGES  = 2      // must be at least 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] data,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [4:0] cursor_addr,
    output logic       display_on,
    output logic       cmd_strobe,
    output logic [8:0] cmd_code,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       viol
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic       e;
        logic [7:0] data;
    } bus_t;

    function automatic logic [4:0] step(input logic [4:0] addr, input logic up);
        return up ? addr + 5'd1 : addr - 5'd1;
    endfunction

    bus_t       sync_q [SYNC_STAGES];
    bus_t       sync_d [SYNC_STAGES];
    bus_t       bus_s;
    logic       e_prev_q, e_prev_d;
    logic       fall, rise;

    state_t     state_q, state_d;
    logic [8:0] cmd_q, cmd_d;
    logic [7:0] ddram_q [32];
    logic [7:0] ddram_d [32];
    logic [4:0] cursor_q, cursor_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic       id_q, id_d;
    logic       display_on_q, display_on_d;
    logic       cursor_on_q, cursor_on_d;
    logic       blink_q, blink_d;
    logic [2:0] func_q, func_d;
    cnt_t       busy_cnt_q, busy_cnt_d, busy_dec;
    logic       busy_q, busy_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       cmd_strobe_q, cmd_strobe_d;
    logic [8:0] cmd_code_q, cmd_code_d;
    logic [7:0] rd_char_q, rd_char_d;
    logic       viol_q, viol_d;

    always_comb begin
        sync_d[0] = {RS, RW, E, data};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    assign bus_s    = sync_q[SYNC_STAGES-1];
    assign e_prev_d = bus_s.e;
    assign fall     = e_prev_q & ~bus_s.e;
    assign rise     = ~e_prev_q & bus_s.e;
    assign busy_dec = (busy_cnt_q != '0) ? busy_cnt_q - cnt_t'(1) : '0;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cmd_d        = cmd_q;
        ddram_d      = ddram_q;
        cursor_d     = cursor_q;
        clr_idx_d    = clr_idx_q;
        id_d         = id_q;
        display_on_d = display_on_q;
        cursor_on_d  = cursor_on_q;
        blink_d      = blink_q;
        func_d       = func_q;
        busy_cnt_d   = busy_dec;
        data_out_d   = data_out_q;
        data_oe_d    = bus_s.rw & bus_s.e;
        cmd_strobe_d = 1'b0;
        cmd_code_d   = cmd_code_q;
        rd_char_d    = ddram_q[rd_addr];
        viol_d       = viol_q;

        if (rise && bus_s.rw && state_q != ST_CLEAR) begin
            data_out_d = bus_s.rs ? ddram_q[cursor_q]
                                  : {busy_q, cursor_q[4], 2'b00, cursor_q[3:0]};
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!bus_s.rw) begin
`ifdef LCD_BUSY_CHECK_EN
                        if (busy_q) begin
                            viol_d = 1'b1;
                        end else begin
                            cmd_d   = {bus_s.rs, bus_s.data};
                            state_d = ST_EXEC;
                        end
`else
                        cmd_d   = {bus_s.rs, bus_s.data};
                        state_d = ST_EXEC;
`endif
                    end else if (bus_s.rs) begin
                        cursor_d = step(cursor_q, id_q);
                    end
                end
            end

            ST_EXEC: begin
                state_d      = ST_IDLE;
                cmd_strobe_d = 1'b1;
                cmd_code_d   = cmd_q;
                busy_cnt_d   = cnt_t'(BUSY_CYCLES);
                if (cmd_q[8]) begin
                    ddram_d[cursor_q] = cmd_q[7:0];
                    cursor_d          = step(cursor_q, id_q);
                end else if (cmd_q[7]) begin
                    // Only the two visible 16-cell windows are addressable.
                    if (cmd_q[6:4] == 3'b000)      cursor_d = {1'b0, cmd_q[3:0]};
                    else if (cmd_q[6:4] == 3'b100) cursor_d = {1'b1, cmd_q[3:0]};
                end else if (cmd_q[6]) begin
                    cursor_d = cursor_q;
                end else if (cmd_q[5]) begin
                    func_d = cmd_q[4:2];
                end else if (cmd_q[4]) begin
                    if (!cmd_q[3]) cursor_d = step(cursor_q, cmd_q[2]);
                end else if (cmd_q[3]) begin
                    {display_on_d, cursor_on_d, blink_d} = cmd_q[2:0];
                end else if (cmd_q[2]) begin
                    id_d = cmd_q[1];
                end else if (cmd_q[1]) begin
                    cursor_d   = '0;
                    busy_cnt_d = cnt_t'(CLEAR_CYCLES);
                end else if (cmd_q[0]) begin
                    state_d    = ST_CLEAR;
                    clr_idx_d  = '0;
                    busy_cnt_d = cnt_t'(CLEAR_CYCLES);
                end else begin
                    busy_cnt_d = busy_dec;
                end
            end

            ST_CLEAR: begin
                ddram_d[clr_idx_q] = 8'h20;
                clr_idx_d          = clr_idx_q + 5'd1;
                if (rise || fall) viol_d = 1'b1;
                if (clr_idx_q == 5'd31) begin
                    state_d  = ST_IDLE;
                    cursor_d = '0;
                    id_d     = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (busy_cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_prev_q     <= 1'b0;
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            // NOTE: the DDRAM mirror is built from resettable flops because the panel powers up showing blanks.
            for (int i = 0; i < 32; i++) ddram_q[i] <= 8'h20;
            cursor_q     <= '0;
            clr_idx_q    <= '0;
            id_q         <= 1'b1;
            display_on_q <= 1'b0;
            cursor_on_q  <= 1'b0;
            blink_q      <= 1'b0;
            func_q       <= '0;
            busy_cnt_q   <= '0;
            busy_q       <= 1'b0;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= '0;
            rd_char_q    <= '0;
            viol_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            e_prev_q     <= e_prev_d;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            ddram_q      <= ddram_d;
            cursor_q     <= cursor_d;
            clr_idx_q    <= clr_idx_d;
            id_q         <= id_d;
            display_on_q <= display_on_d;
            cursor_on_q  <= cursor_on_d;
            blink_q      <= blink_d;
            func_q       <= func_d;
            busy_cnt_q   <= busy_cnt_d;
            busy_q       <= busy_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_code_q   <= cmd_code_d;
            rd_char_q    <= rd_char_d;
            viol_q       <= viol_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;
    assign busy        = busy_q;
    assign cursor_addr = cursor_q;
    assign display_on  = display_on_q;
    assign cmd_strobe  = cmd_strobe_q;
    assign cmd_code    = cmd_code_q;
    assign rd_char     = rd_char_q;
    assign viol        = viol_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: directed steps plus randomized traffic checked against a panel model.
module tb_lcd_bus_responder;

    localparam int BUSY_CYC  = 200;
    localparam int CLEAR_CYC = 600;
    localparam int GAP       = BUSY_CYC + 100;
    localparam int CGAP      = CLEAR_CYC + 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RS = 1'b0, RW = 1'b0, E = 1'b0;
    logic [7:0] data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] data_out, rd_char;
    logic       data_oe, busy, display_on, cmd_strobe, viol;
    logic [4:0] cursor_addr;
    logic [8:0] cmd_code;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int busy_run = 0;

    // Panel model state
    logic [7:0] mem [32];
    int         cur;
    bit         id;
    bit         disp;

    always #5 clk = ~clk;

    lcd_bus_responder #(
        .BUSY_CYCLES (BUSY_CYC),
        .CLEAR_CYCLES(CLEAR_CYC),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RS         (RS),
        .RW         (RW),
        .E          (E),
        .data       (data),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .busy       (busy),
        .cursor_addr(cursor_addr),
        .display_on (display_on),
        .cmd_strobe (cmd_strobe),
        .cmd_code   (cmd_code),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .viol       (viol)
    );

    always @(negedge clk) begin
        if (cmd_strobe) strobes++;
        if (busy) busy_run++;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int step(input int c, input bit up);
        return up ? (c + 1) % 32 : (c + 31) % 32;
    endfunction

    function automatic logic [6:0] addr7(input int c);
        return (c < 16) ? 7'(c) : 7'(64 + c - 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 8'h20;
        cur  = 0;
        id   = 1'b1;
        disp = 1'b0;
    endtask

    task automatic model_write(input logic rs, input logic [7:0] d);
        int a;
        a = int'(d & 8'h7F);
        if (rs) begin
            mem[cur] = d;
            cur = step(cur, id);
        end else if (d >= 8'h80) begin
            if (a <= 15) cur = a;
            else if (a >= 64 && a <= 79) cur = a - 48;
        end else if (d >= 8'h20) begin
            // CGRAM address and function set leave the visible state alone
        end else if (d >= 8'h10) begin
            if (d < 8'h18) cur = step(cur, d[2]);
        end else if (d >= 8'h08) begin
            disp = d[2];
        end else if (d >= 8'h04) begin
            id = d[1];
        end else if (d >= 8'h02) begin
            cur = 0;
        end else if (d == 8'h01) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'h20;
            cur = 0;
            id  = 1'b1;
        end
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        RS = rs; RW = 1'b0; data = d;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (4) @(negedge clk);
        E = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] dout, output logic oe_hi, output logic oe_lo);
        @(negedge clk);
        RS = rs; RW = 1'b1;
        repeat (2) @(negedge clk);
        E = 1'b1;
        repeat (5) @(negedge clk);
        oe_hi = data_oe;
        dout  = data_out;
        E = 1'b0;
        repeat (6) @(negedge clk);
        oe_lo = data_oe;
        RW = 1'b0;
    endtask

    task automatic peek(input int a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = 5'(a);
        repeat (2) @(negedge clk);
        v = rd_char;
    endtask

    task automatic check_all_mem(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            peek(i, v);
            check($sformatf("%s[%0d]", tag, i), v, mem[i]);
        end
    endtask

    // Accepted write: one strobe, correct code, then settle past busy and compare the cursor.
    task automatic do_write(input string tag, input logic rs, input logic [7:0] d, input int gap);
        int s0;
        s0 = strobes;
        bus_write(rs, d);
        model_write(rs, d);
        check({tag, "_strobe"}, strobes - s0, 1);
        check({tag, "_code"}, cmd_code, {rs, d});
        repeat (gap) @(negedge clk);
        check({tag, "_cursor"}, cursor_addr, cur);
    endtask

    initial begin
        logic [7:0] v, dout;
        logic       oe_hi, oe_lo;
        int         s0, b0, op;
        logic [7:0] d;

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_cursor", cursor_addr, 0);
        check("rst_display_on", display_on, 0);
        check("rst_viol", viol, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_data_out", data_out, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_strobes", strobes, 0);
        check_all_mem("rst_ddram");

        do_write("fset", 1'b0, 8'h38, GAP);
        do_write("dctl", 1'b0, 8'h0E, GAP);
        do_write("emode", 1'b0, 8'h06, GAP);
        check("display_on_set", display_on, disp);

        do_write("pre_a", 1'b1, 8'h41, GAP);
        do_write("pre_b", 1'b1, 8'h42, GAP);
        check("pre_clear_cell1", mem[1], 8'h42);
        peek(1, v);
        check("pre_clear_ddram1", v, 8'h42);

        // Clear: busy asserted promptly and held for CLEAR_CYC cycles in total
        b0 = busy_run;
        s0 = strobes;
        bus_write(1'b0, 8'h01);
        model_write(1'b0, 8'h01);
        check("clear_busy_now", busy, 1);
        check("clear_strobe", strobes - s0, 1);
        repeat (CGAP) @(negedge clk);
        check("clear_busy_done", busy, 0);
        check("clear_busy_len", (busy_run - b0 >= CLEAR_CYC - 1) && (busy_run - b0 <= CLEAR_CYC + 1), 1);
        check("clear_cursor", cursor_addr, 0);
        check_all_mem("clear_ddram");

        do_write("addr_0f", 1'b0, 8'h8F, GAP);
        do_write("data_50", 1'b1, 8'h50, GAP);
        do_write("data_51", 1'b1, 8'h51, GAP);
        peek(15, v); check("ddram15", v, 8'h50);
        peek(16, v); check("ddram16", v, 8'h51);
        check("cursor17", cursor_addr, 17);
        do_write("addr_4f", 1'b0, 8'hCF, GAP);
        do_write("data_41", 1'b1, 8'h41, GAP);
        peek(31, v); check("ddram31", v, 8'h41);
        check("cursor_wrap", cursor_addr, 0);

        // Busy-flag read shortly after a data write, then again once idle
        bus_write(1'b1, 8'h42);
        model_write(1'b1, 8'h42);
        repeat (4) @(negedge clk);
        bus_read(1'b0, dout, oe_hi, oe_lo);
        check("bread_busy_oe_hi", oe_hi, 1);
        check("bread_busy_oe_lo", oe_lo, 0);
        check("bread_busy_val", dout, {1'b1, addr7(cur)});
        repeat (GAP) @(negedge clk);
        bus_read(1'b0, dout, oe_hi, oe_lo);
        check("bread_idle_val", dout, {1'b0, addr7(cur)});

        // Randomized traffic against the model
        for (int n = 0; n < 24; n++) begin
            op = int'($urandom_range(0, 6));
            case (op)
                0, 1: do_write($sformatf("r%0d_data", n), 1'b1, 8'($urandom_range(8'h21, 8'h7E)), GAP);
                2: begin
                    if ($urandom_range(0, 1) == 1)
                        d = 8'h80 | 8'($urandom_range(0, 127));
                    else
                        d = 8'h80 | ($urandom_range(0, 1) == 1 ? 8'h40 : 8'h00) | 8'($urandom_range(0, 15));
                    do_write($sformatf("r%0d_addr", n), 1'b0, d, GAP);
                end
                3: do_write($sformatf("r%0d_emode", n), 1'b0, 8'h04 | 8'($urandom_range(0, 3)), GAP);
                4: do_write($sformatf("r%0d_shift", n), 1'b0, 8'h10 | 8'($urandom_range(0, 15)), GAP);
                5: begin
                    s0 = strobes;
                    bus_read(1'b1, dout, oe_hi, oe_lo);
                    check($sformatf("r%0d_dread", n), dout, mem[cur]);
                    check($sformatf("r%0d_dread_nostrobe", n), strobes - s0, 0);
                    cur = step(cur, id);
                    check($sformatf("r%0d_dread_cursor", n), cursor_addr, cur);
                end
                default: do_write($sformatf("r%0d_home", n), 1'b0, 8'h02 | 8'($urandom_range(0, 1)), CGAP);
            endcase
        end
        check_all_mem("rand_ddram");
        check("viol_clean", viol, 0);

        // Second data write ~100 cycles after the first, well inside busy
        s0 = strobes;
        bus_write(1'b1, 8'h58);
        model_write(1'b1, 8'h58);
        repeat (85) @(negedge clk);
        bus_write(1'b1, 8'h41);
`ifdef LCD_BUSY_CHECK_EN
        check("busychk_strobes", strobes - s0, 1);
        check("busychk_viol", viol, 1);
`else
        model_write(1'b1, 8'h41);
        check("busychk_strobes", strobes - s0, 2);
        check("busychk_viol", viol, 0);
`endif
        repeat (GAP) @(negedge clk);
        check("busychk_cursor", cursor_addr, cur);
        check_all_mem("busychk_ddram");

        // E pulse while the clear walk is running is dropped and flagged
        s0 = strobes;
        bus_write(1'b0, 8'h01);
        model_write(1'b0, 8'h01);
        @(negedge clk);
        RS = 1'b1; RW = 1'b0; data = 8'h99; E = 1'b1;
        repeat (2) @(negedge clk);
        E = 1'b0;
        repeat (CGAP) @(negedge clk);
        check("cleardrop_viol", viol, 1);
        check("cleardrop_strobes", strobes - s0, 1);
        check("cleardrop_cursor", cursor_addr, 0);
        check_all_mem("cleardrop_ddram");

        // Reset in the middle of a busy period
        bus_write(1'b1, 8'h55);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_viol", viol, 0);
        check("midrst_cursor", cursor_addr, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        peek(0, v);
        check("midrst_ddram0", v, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable HD44780-compatible responder for the 8-bit LCD bus. It is the panel side of the interface that the existing LCD controller drives.
- Samples RS/RW/E/data in the system clock domain and decodes the instruction subset the controller issues.
- Maintains a 32-cell DDRAM mirror (2 lines x 16), a cursor address and a busy flag, and answers busy/data reads.
- Used on-board to mirror LCD traffic onto debug outputs, and in simulation as the bus model for controller testbenches.

Parameters:
- BUSY_CYCLES, 2000: busy duration in clk cycles after any instruction or data write except clear/home (40 us at 50 MHz).
- CLEAR_CYCLES, 76500: busy duration after clear display or return home (1.53 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer depth on RS, RW, E and data (minimum 2).

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous active-low reset.
- RS  in  1  register select: 0 = instruction, 1 = data.
- RW  in  1  0 = write, 1 = read.
- E  in  1  enable; writes are latched on its falling edge.
- data  in  8  write bus DB7..0.
- data_out  out  8  read bus value.
- data_oe  out  1  read bus drive enable.
- busy  out  1  busy flag.
- cursor_addr  out  5  current DDRAM cell, 0..31.
- display_on  out  1  D bit of display control.
- cmd_strobe  out  1  one-cycle pulse per accepted write.
- cmd_code  out  9  {RS, data} of the last accepted write.
- rd_addr  in  5  debug DDRAM read address.
- rd_char  out  8  DDRAM[rd_addr], registered, 1-cycle latency.
- viol  out  1  sticky write-while-busy flag.

Behaviour:
- Reset (async, rst=0):
  - All 32 DDRAM cells = 0x20.
  - cursor_addr=0, I/D=1, display_on=0, busy=0.
  - data_out=0, data_oe=0, cmd_strobe=0, cmd_code=0, viol=0, rd_char=0.
  - Busy counter=0; synchronizers cleared, with the E history forced to 0.
  - Reset mid-clear or mid-busy aborts immediately.
- Sampling:
  - All bus inputs pass through SYNC_STAGES flops.
  - Falling edge = previous synced E is 1 and current synced E is 0.
  - RS, RW and data are taken from the same synced stage as E.
  - Event latency: cmd_strobe and the DDRAM write occur 1 cycle after falling-edge detection.
- Write decode (RW=0), priority from MSB:
  - RS=1: DDRAM[cursor]=data, then advance cursor.
  - 1xxxxxxx: set DDRAM address.
    - Address 0x00-0x0F maps to cells 0-15; 0x40-0x4F maps to cells 16-31.
    - Any other address: cursor unchanged, write still counts as accepted.
  - 01xxxxxx: CGRAM address; accepted, no effect.
  - 001xxxxx: function set; stored internally, no effect on outputs.
  - 0001 S/C R/L xx: if S/C=0, move cursor +1 (R/L=1) or -1 (R/L=0); S/C=1 is a no-op.
  - 00001DCB: display_on=D; C and B are stored.
  - 000001 I/D S: latch I/D; S is ignored.
  - 0000001x: return home; cursor=0; busy for CLEAR_CYCLES.
  - 00000001: clear display.
    - FSM CLEAR walks cells 0..31 writing 0x20, one per cycle (32 cycles).
    - Then cursor=0, I/D=1, busy for CLEAR_CYCLES counted from clear start.
  - 0x00: no-op, no busy.
- Cursor advance:
  - By I/D: +1 or -1, modulo 32 (31+1 -> 0, 0-1 -> 31).
- Busy:
  - Counter loads on each accepted write and decrements each clk; busy=1 while counter is nonzero.
  - An accepted write during busy reloads the counter.
- Read (RW=1):
  - data_oe=1 while synced RW=1 and synced E=1.
  - data_out is registered on the synced rising edge of E:
    - RS=0: {busy, DDRAM address in 7 bits, i.e. cells 16-31 read as 0x40+n}.
    - RS=1: DDRAM[cursor].
  - Data reads advance the cursor on the falling edge of E.
  - Reads never set busy and never pulse cmd_strobe.
- FSM states:
  - IDLE -> (write event) EXEC -> IDLE.
  - IDLE -> (clear) CLEAR (32 cycles) -> IDLE.
  - E edges arriving during CLEAR are dropped and set viol.
- Simultaneous events: a debug rd_addr read in the same cycle as a DDRAM write to that cell returns the old value.

Optional Feature:
- Macro: LCD_BUSY_CHECK_EN.
- Defined: writes arriving while busy=1 are discarded (no DDRAM/cursor/state change, no cmd_strobe) and set viol, which stays sticky until reset.
- Undefined: writes are always accepted regardless of busy; viol is set only by CLEAR-phase drops.

Test Plan:
- Reset then idle 10 cycles -> rd_char=0x20 for all 32 addresses, busy=0, cursor_addr=0, display_on=0.
- Writes 0x38, 0x0E, 0x06, each followed by a 2100-cycle gap -> display_on=1, I/D=1, cmd_code sequence 0x038, 0x00E, 0x006, one cmd_strobe each.
- Write 0x01 -> busy=1 within 2 cycles, stays high 76500 cycles; all cells then 0x20, cursor_addr=0.
- Write 0x8F, then RS=1 data 0x50 and 0x51 with 2100-cycle gaps -> DDRAM[15]=0x50, DDRAM[16]=0x51, cursor_addr=17. Repeat from 0xCF with 0x41 -> DDRAM[31]=0x41, cursor wraps to 0.
- Busy read (RS=0, RW=1) 10 cycles after a data write -> data_oe=1 during E high, data_out[7]=1, address field correct. Repeat after busy clears -> data_out[7]=0.
- With LCD_BUSY_CHECK_EN, data write 0x41 issued 100 cycles after a previous write -> DDRAM unchanged, viol=1, no cmd_strobe. Without the macro -> write lands, viol=0.
